// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM definitions: Detect substate encoding and 12 ms timing constants.
package pcie_ltssm_pkg;

  localparam int unsigned CLK_FREQ_HZ        = 200000000;
  localparam int unsigned DETECT_12MS_CYCLES = 2400000;

  typedef enum logic [2:0] {
    DET_IDLE    = 3'd0,
    DET_QUIET   = 3'd1,
    DET_ACTIVE1 = 3'd2,
    DET_WAIT    = 3'd3,
    DET_ACTIVE2 = 3'd4,
    DET_POLLING = 3'd5
  } detect_state_e;

endpackage

// File: rtl/detect_timer.sv
// Loadable-limit up-counter shared by every timed Detect substate.
module detect_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] limit_i,
  output logic        expired_o
);

  logic [31:0] r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_count <= '0;
    else if (clr_i)  r_count <= '0;
    else if (en_i)   r_count <= r_count + 32'd1;
  end

  // Fires on the last cycle of the window so the owner can leave on the next edge.
  assign expired_o = en_i && (r_count == (limit_i - 32'd1));

endmodule

// File: rtl/detect_ctrl.sv
// PCIe LTSSM Detect sequencer: Quiet dwell, receiver detect, partial-detect retry, Polling handoff.
module detect_ctrl
  import pcie_ltssm_pkg::*;
#(
  parameter int NUM_LANES            = 4,
  parameter int TIMEOUT_CYCLES       = DETECT_12MS_CYCLES,
  parameter int RXDET_TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] elec_idle_exit_i,
  input  logic                 rx_det_done_i,
  input  logic [NUM_LANES-1:0] rx_det_result_i,
  output logic                 rx_det_req_o,
  output logic [2:0]           state_o,
  output logic                 polling_o,
  output logic [NUM_LANES-1:0] lanes_active_o
);

  localparam logic [31:0]          LIM_12MS  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0]          LIM_RXDET = 32'(RXDET_TIMEOUT_CYCLES);
  localparam logic [NUM_LANES-1:0] ALL_LANES = '1;

  detect_state_e        r_state, w_next;
  logic                 r_fresh;
  logic [NUM_LANES-1:0] r_mask, w_mask_next;
  logic [NUM_LANES-1:0] r_lanes, w_lanes_next;
  logic                 w_timer_en, w_timer_clr, w_expired;
  logic [31:0]          w_limit;
  logic                 w_done_ok;

  assign w_timer_en  = (r_state == DET_QUIET) || (r_state == DET_WAIT) ||
                       (r_state == DET_ACTIVE1) || (r_state == DET_ACTIVE2);
  assign w_limit     = ((r_state == DET_QUIET) || (r_state == DET_WAIT)) ? LIM_12MS : LIM_RXDET;
  assign w_timer_clr = (w_next != r_state);
  // A done pulse in the same cycle as our request cannot answer it.
  assign w_done_ok   = rx_det_done_i && !r_fresh;

  detect_timer u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_timer_clr),
    .en_i      (w_timer_en),
    .limit_i   (w_limit),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= DET_IDLE;
      r_fresh <= 1'b0;
      r_mask  <= '0;
      r_lanes <= '0;
    end else begin
      r_state <= w_next;
      r_fresh <= (w_next != r_state);
      r_mask  <= w_mask_next;
      r_lanes <= w_lanes_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mask_next = r_mask;
    if (!en_i) begin
      w_next      = DET_IDLE;
      w_mask_next = '0;
    end else begin
      case (r_state)
        DET_IDLE:  w_next = DET_QUIET;
        DET_QUIET: if ((|elec_idle_exit_i) || w_expired) w_next = DET_ACTIVE1;
        DET_ACTIVE1: begin
          if (w_done_ok) begin
            if (rx_det_result_i == ALL_LANES) begin
              w_next = DET_POLLING;
            end else if (rx_det_result_i == '0) begin
              w_next = DET_QUIET;
            end else begin
              w_next      = DET_WAIT;
              w_mask_next = rx_det_result_i;
            end
          end else if (w_expired) begin
            w_next = DET_QUIET;
          end
        end
        DET_WAIT: if (w_expired) w_next = DET_ACTIVE2;
        DET_ACTIVE2: begin
          if (w_done_ok && (rx_det_result_i == r_mask)) begin
            w_next = DET_POLLING;
          end else if (w_done_ok || w_expired) begin
            w_next      = DET_QUIET;
            w_mask_next = '0;
          end
        end
        DET_POLLING: w_next = DET_POLLING;
        default:     w_next = DET_IDLE;
      endcase
    end
  end

  // Lane set is captured on entry to POLLING and held until we leave.
  always_comb begin
    w_lanes_next = '0;
    if (w_next == DET_POLLING) begin
      if (r_state == DET_POLLING)      w_lanes_next = r_lanes;
      else if (r_state == DET_ACTIVE1) w_lanes_next = ALL_LANES;
      else                             w_lanes_next = r_mask;
    end
  end

  always_comb begin
    state_o        = r_state;
    rx_det_req_o   = r_fresh && ((r_state == DET_ACTIVE1) || (r_state == DET_ACTIVE2));
    polling_o      = (r_state == DET_POLLING);
    lanes_active_o = r_lanes;
  end

endmodule

// File: tb/tb_detect_ctrl.sv
// Scoreboard bench for detect_ctrl: directed Detect scenarios plus randomized traffic vs a cycle-level reference model.
module tb_detect_ctrl;

  localparam int NL = 4;
  localparam int TO = 16;
  localparam int RX = 32;

  localparam int S_IDLE = 0, S_QUIET = 1, S_ACT1 = 2, S_WAIT = 3, S_ACT2 = 4, S_POLL = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NL-1:0] eie;
  logic          done;
  logic [NL-1:0] res;
  logic          req;
  logic [2:0]    st;
  logic          poll;
  logic [NL-1:0] lanes;

  detect_ctrl #(
    .NUM_LANES            (NL),
    .TIMEOUT_CYCLES       (TO),
    .RXDET_TIMEOUT_CYCLES (RX)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .en_i             (en),
    .elec_idle_exit_i (eie),
    .rx_det_done_i    (done),
    .rx_det_result_i  (res),
    .rx_det_req_o     (req),
    .state_o          (st),
    .polling_o        (poll),
    .lanes_active_o   (lanes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          req;
    logic          poll;
    logic [NL-1:0] lanes;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: substate, cycles already spent in it, stored mask, granted lanes.
  int            m_st  = S_IDLE;
  int            m_cnt = 0;
  logic [NL-1:0] m_mask  = '0;
  logic [NL-1:0] m_lanes = '0;

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_mask = '0; m_lanes = '0;
  endtask

  task automatic model_step(input logic e, input logic [NL-1:0] x, input logic d,
                            input logic [NL-1:0] r);
    int   nx;
    bit   answer;
    exp_t ex;
    nx     = m_st;
    answer = d && (m_cnt > 0);
    if (!e) begin
      nx = S_IDLE; m_mask = '0;
    end else begin
      case (m_st)
        S_IDLE:  nx = S_QUIET;
        S_QUIET: if (x != 0 || m_cnt + 1 == TO) nx = S_ACT1;
        S_ACT1: begin
          if (answer && r == 4'hF)   nx = S_POLL;
          else if (answer && r == 0) nx = S_QUIET;
          else if (answer) begin nx = S_WAIT; m_mask = r; end
          else if (m_cnt + 1 == RX)  nx = S_QUIET;
        end
        S_WAIT: if (m_cnt + 1 == TO) nx = S_ACT2;
        S_ACT2: begin
          if (answer && r == m_mask) nx = S_POLL;
          else if (answer || m_cnt + 1 == RX) begin nx = S_QUIET; m_mask = '0; end
        end
        default: nx = S_POLL;
      endcase
    end
    if (nx != S_POLL)     m_lanes = '0;
    else if (m_st == S_ACT1) m_lanes = 4'hF;
    else if (m_st != S_POLL) m_lanes = m_mask;
    ex.st    = 3'(nx);
    ex.req   = (nx == S_ACT1 || nx == S_ACT2) && (nx != m_st);
    ex.poll  = (nx == S_POLL);
    ex.lanes = m_lanes;
    m_cnt = (nx != m_st) ? 0 : m_cnt + 1;
    m_st  = nx;
    q.push_back(ex);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what must appear after the next rise.
  task automatic cyc(input logic e, input logic [NL-1:0] x, input logic d, input logic [NL-1:0] r);
    @(negedge clk);
    en = e; eie = x; done = d; res = r;
    model_step(e, x, d, r);
  endtask

  task automatic step(input logic e, input logic [NL-1:0] x, input logic d, input logic [NL-1:0] r);
    cyc(e, x, d, r);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req_v, $time);
    end
  endtask

  task automatic dwell(input int s, output int n);
    n = 0;
    while (int'(st) == s && n < 200) begin
      n++;
      step(1, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; eie = 0; done = 0; res = 0;
    rst = 1'b1;
    #1;
    chk("rst_state", int'(st), S_IDLE);
    chk("rst_req", int'(req), 0);
    chk("rst_poll", int'(poll), 0);
    chk("rst_lanes", int'(lanes), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every rising edge, the oldest queued expectation is due.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        n_cmp++;
        if ({st, req, poll, lanes} !== ex) begin
          n_bad++;
          $display("FAIL scoreboard: got st=%0d req=%0b poll=%0b lanes=%b, required st=%0d req=%0b poll=%0b lanes=%b at %0t",
                   st, req, poll, lanes, ex.st, ex.req, ex.poll, ex.lanes, $time);
        end
      end
    end
  end

  initial begin
    int n;
    int reqs;
    logic [NL-1:0] x, r;
    logic e, d;
    rst = 1'b1; en = 0; eie = 0; done = 0; res = 0;
    #1;
    chk("por_state", int'(st), S_IDLE);
    chk("por_poll", int'(poll), 0);
    @(negedge clk);
    rst = 1'b0;

    // Quiet timeout, full detect
    step(1, 0, 0, 0);
    dwell(S_QUIET, n);
    chk("quiet_dwell", n, TO);
    chk("act1_state", int'(st), S_ACT1);
    chk("act1_req", int'(req), 1);
    step(1, 0, 0, 0);
    chk("act1_req_once", int'(req), 0);
    step(1, 0, 1, 4'hF);
    chk("full_poll", int'(poll), 1);
    chk("full_lanes", int'(lanes), 4'hF);
    step(1, 4'hF, 1, 4'h3);
    chk("poll_hold", int'(lanes), 4'hF);

    // Abort from POLLING
    step(0, 0, 0, 0);
    chk("abort_poll_state", int'(st), S_IDLE);
    chk("abort_poll_out", int'({poll, lanes}), 0);

    // Early exit on QUIET cycle 3, then zero result restarts the dwell
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 4'b0100, 0, 0);
    chk("early_exit", int'(st), S_ACT1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'h0);
    chk("zero_to_quiet", int'(st), S_QUIET);
    dwell(S_QUIET, n);
    chk("quiet_redwell", n, TO);

    // Partial match
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'b0011);
    chk("partial_wait", int'(st), S_WAIT);
    dwell(S_WAIT, n);
    chk("wait_dwell", n, TO);
    chk("act2_req", int'(req), 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'b0011);
    chk("match_poll", int'(poll), 1);
    chk("match_lanes", int'(lanes), 4'b0011);

    // Partial mismatch
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 4'b0001, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'b0011);
    dwell(S_WAIT, n);
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'b0001);
    chk("mismatch_state", int'(st), S_QUIET);
    chk("mismatch_poll", int'(poll), 0);

    // PHY silent
    step(1, 4'b1000, 0, 0);
    reqs = 0;
    n = 0;
    while (int'(st) == S_ACT1 && n < 200) begin
      reqs += int'(req);
      n++;
      step(1, 0, 0, 0);
    end
    chk("silent_dwell", n, RX);
    chk("silent_reqs", reqs, 1);
    chk("silent_quiet", int'(st), S_QUIET);

    // Abort during WAIT
    step(1, 4'b0010, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'b0110);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_wait_state", int'(st), S_IDLE);
    chk("abort_wait_out", int'({req, poll, lanes}), 0);

    // Reset mid-ACTIVE1
    step(1, 0, 0, 0);
    step(1, 4'b0001, 0, 0);
    step(1, 0, 0, 0);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 149) != 0);
      x = ($urandom_range(0, 24) == 0) ? NL'($urandom_range(1, 15)) : '0;
      d = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0:       r = 4'hF;
        1:       r = 4'h0;
        2, 3:    r = (m_mask != 0) ? m_mask : NL'($urandom_range(1, 14));
        default: r = NL'($urandom_range(0, 15));
      endcase
      cyc(e, x, d, r);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
